// File: rtl/layer_reg_scheduler.sv
// Arbitrates the layer register bank between buffered host writes, a per-frame
// render scan of every layer, and a bulk clear. Host writes wait out a running scan.
module layer_reg_scheduler #(
    parameter int unsigned NUM_LAYERS = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_frame_start,
    input  logic              i_clear_req,
    input  logic              i_host_wr_valid,
    output logic              o_host_wr_ready,
    input  logic [ADDR_W-1:0] i_host_wr_addr,
    input  logic [DATA_W-1:0] i_host_wr_data,
    input  logic [ADDR_W-1:0] i_host_rd_addr,
    output logic [DATA_W-1:0] o_host_rd_data,
    output logic              o_scan_valid,
    output logic [ADDR_W-1:0] o_scan_layer,
    output logic [DATA_W-1:0] o_scan_data,
    output logic              o_scan_done,
    output logic              o_busy,
    output logic              o_overrun,
    output logic [ADDR_W-1:0] o_mem_rd_addr1,
    output logic [ADDR_W-1:0] o_mem_rd_addr2,
    input  logic [DATA_W-1:0] i_mem_rd_data1,
    input  logic [DATA_W-1:0] i_mem_rd_data2,
    output logic              o_mem_wr_en,
    output logic [ADDR_W-1:0] o_mem_wr_addr,
    output logic [DATA_W-1:0] o_mem_wr_data
);

    localparam int unsigned       PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]    FullCnt = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_LAYERS - 1);

    typedef enum logic [1:0] {StIdle, StScan, StClear} state_t;

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_idx, w_idx_next;
    logic              r_pending_frame, w_pending_frame_next;
    logic              r_pending_clear, w_pending_clear_next;

    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W:0]    r_wr_ptr, r_rd_ptr;
    logic              w_empty, w_full, w_push, w_pop, w_ready;

    logic              r_scan_valid, r_scan_done, r_overrun;
    logic [ADDR_W-1:0] r_scan_layer;
    logic [DATA_W-1:0] r_scan_data, r_host_rd_data;
    logic              w_last;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = ((r_wr_ptr - r_rd_ptr) == FullCnt);
    assign w_ready = !w_full && !i_reset;
    assign w_push  = i_host_wr_valid && w_ready;
    assign w_last  = (r_idx == LastIdx);

    always_comb begin
        w_state_next         = r_state;
        w_idx_next           = r_idx;
        w_pending_frame_next = r_pending_frame;
        w_pending_clear_next = r_pending_clear;
        w_pop                = 1'b0;
        o_mem_wr_en          = 1'b0;
        o_mem_wr_addr        = r_fifo_addr[r_rd_ptr[PTR_W-1:0]];
        o_mem_wr_data        = r_fifo_data[r_rd_ptr[PTR_W-1:0]];
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    o_mem_wr_en = 1'b1;
                    w_pop       = 1'b1;
                end
                if (i_clear_req || r_pending_clear) begin
                    w_state_next         = StClear;
                    w_pending_clear_next = 1'b0;
                    w_pending_frame_next = r_pending_frame || i_frame_start;
                end else if (i_frame_start || r_pending_frame) begin
                    w_state_next         = StScan;
                    w_pending_frame_next = 1'b0;
                end
            end
            StScan: begin
                if (i_clear_req) w_pending_clear_next = 1'b1;
                if (w_last) begin
                    w_state_next = StIdle;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next = r_idx + 1'b1;
                end
            end
            StClear: begin
                o_mem_wr_en   = 1'b1;
                o_mem_wr_addr = r_idx;
                o_mem_wr_data = '0;
                if (i_frame_start) w_pending_frame_next = 1'b1;
                if (w_last) begin
                    w_state_next = StIdle;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next = r_idx + 1'b1;
                end
            end
            default: begin
                w_state_next = StIdle;
                w_idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state         <= StIdle;
            r_idx           <= '0;
            r_pending_frame <= 1'b0;
            r_pending_clear <= 1'b0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_scan_valid    <= 1'b0;
            r_scan_layer    <= '0;
            r_scan_data     <= '0;
            r_scan_done     <= 1'b0;
            r_overrun       <= 1'b0;
            r_host_rd_data  <= '0;
        end else begin
            r_state         <= w_state_next;
            r_idx           <= w_idx_next;
            r_pending_frame <= w_pending_frame_next;
            r_pending_clear <= w_pending_clear_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_scan_valid <= (r_state == StScan);
            r_scan_done  <= (r_state == StScan) && w_last;
            r_overrun    <= (r_state == StScan) && i_frame_start;
            if (r_state == StScan) begin
                r_scan_layer <= r_idx;
                r_scan_data  <= i_mem_rd_data1;
            end
            r_host_rd_data <= i_mem_rd_data2;
        end
    end

    // Storage needs no reset; the pointers define which slots are live.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr[PTR_W-1:0]] <= i_host_wr_addr;
            r_fifo_data[r_wr_ptr[PTR_W-1:0]] <= i_host_wr_data;
        end
    end

    assign o_host_wr_ready = w_ready;
    assign o_host_rd_data  = r_host_rd_data;
    assign o_scan_valid    = r_scan_valid;
    assign o_scan_layer    = r_scan_layer;
    assign o_scan_data     = r_scan_data;
    assign o_scan_done     = r_scan_done;
    assign o_busy          = (r_state != StIdle);
    assign o_overrun       = r_overrun;
    assign o_mem_rd_addr1  = r_idx;
    assign o_mem_rd_addr2  = i_host_rd_addr;

endmodule

// File: tb/tb_layer_reg_scheduler.sv
// Directed-sequence bench for layer_reg_scheduler with a behavioural memory,
// a shadow register image and an expected host-write queue.
module tb_layer_reg_scheduler;

    logic        clk, reset;
    logic        frame_start, clear_req, host_wr_valid, host_wr_ready;
    logic [4:0]  host_wr_addr, host_rd_addr, scan_layer;
    logic [15:0] host_wr_data, host_rd_data, scan_data;
    logic        scan_valid, scan_done, busy, overrun;
    logic [4:0]  mem_rd_addr1, mem_rd_addr2, mem_wr_addr;
    logic [15:0] mem_rd_data1, mem_rd_data2, mem_wr_data;
    logic        mem_wr_en;

    logic [15:0] mem [32];
    logic        pre_en;
    logic [4:0]  pre_addr;
    logic [15:0] pre_data;

    typedef struct {logic [4:0] a; logic [15:0] d;} wr_t;
    logic [15:0] ref_mem [32];
    wr_t         exp_q [$];
    int          total, bad;

    layer_reg_scheduler dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_frame_start  (frame_start),
        .i_clear_req    (clear_req),
        .i_host_wr_valid(host_wr_valid),
        .o_host_wr_ready(host_wr_ready),
        .i_host_wr_addr (host_wr_addr),
        .i_host_wr_data (host_wr_data),
        .i_host_rd_addr (host_rd_addr),
        .o_host_rd_data (host_rd_data),
        .o_scan_valid   (scan_valid),
        .o_scan_layer   (scan_layer),
        .o_scan_data    (scan_data),
        .o_scan_done    (scan_done),
        .o_busy         (busy),
        .o_overrun      (overrun),
        .o_mem_rd_addr1 (mem_rd_addr1),
        .o_mem_rd_addr2 (mem_rd_addr2),
        .i_mem_rd_data1 (mem_rd_data1),
        .i_mem_rd_data2 (mem_rd_data2),
        .o_mem_wr_en    (mem_wr_en),
        .o_mem_wr_addr  (mem_wr_addr),
        .o_mem_wr_data  (mem_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    end
    assign mem_rd_data1 = mem[mem_rd_addr1];
    assign mem_rd_data2 = mem[mem_rd_addr2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Back-to-back host writes in IDLE: each lands in memory the cycle after acceptance.
    task automatic wr_burst(input int n);
        logic [4:0]  pa;
        logic [15:0] pd;
        pa = '0;
        pd = '0;
        for (int i = 0; i <= n; i++) begin
            if (i > 0) begin
                chk("burst_wr_en", 32'(mem_wr_en), 32'd1);
                chk("burst_wr_addr", 32'(mem_wr_addr), 32'(pa));
                chk("burst_wr_data", 32'(mem_wr_data), 32'(pd));
                ref_mem[pa] = pd;
            end
            if (i < n) begin
                chk("burst_ready", 32'(host_wr_ready), 32'd1);
                pa            = 5'($urandom_range(0, 30));
                pd            = 16'($urandom);
                host_wr_valid = 1'b1;
                host_wr_addr  = pa;
                host_wr_data  = pd;
            end else begin
                host_wr_valid = 1'b0;
            end
            step();
        end
        chk("burst_idle_wr_en", 32'(mem_wr_en), 32'd0);
    endtask

    task automatic rd_check(input int n);
        logic [4:0] a;
        for (int i = 0; i < n; i++) begin
            a            = 5'($urandom_range(0, 31));
            host_rd_addr = a;
            step();
            chk("readback", 32'(host_rd_data), 32'(ref_mem[a]));
        end
    endtask

    // Caller sits at cycle T; the scan occupies T+1..T+32, beats appear T+2..T+33.
    task automatic scan_run(input bit start, input int n_wr, input int fs_k, input int clr_k,
                            input int stop_k);
        int occ;
        occ = 0;
        if (start) frame_start = 1'b1;
        step();
        for (int k = 1; k <= stop_k; k++) begin
            frame_start   = 1'b0;
            clear_req     = 1'b0;
            host_wr_valid = 1'b0;
            if (k >= 2 && k <= 33) begin
                chk("scan_valid", 32'(scan_valid), 32'd1);
                chk("scan_layer", 32'(scan_layer), 32'(k - 2));
                chk("scan_data", 32'(scan_data), 32'(ref_mem[k - 2]));
                chk("scan_done", 32'(scan_done), 32'(k == 33));
            end else begin
                chk("scan_valid_idle", 32'(scan_valid), 32'd0);
                chk("scan_done_idle", 32'(scan_done), 32'd0);
            end
            if (k <= 32) begin
                chk("scan_busy", 32'(busy), 32'd1);
                chk("scan_no_wr", 32'(mem_wr_en), 32'd0);
            end else begin
                chk("scan_end_busy", 32'(busy), 32'd0);
            end
            chk("overrun", 32'(overrun), 32'(k == fs_k + 1));
            chk("scan_ready", 32'(host_wr_ready), 32'(occ < 4));
            if (k < stop_k) begin
                if (k <= n_wr) begin
                    host_wr_valid = 1'b1;
                    host_wr_addr  = 5'($urandom_range(0, 31));
                    host_wr_data  = 16'($urandom);
                    if (occ < 4) begin
                        exp_q.push_back('{a: host_wr_addr, d: host_wr_data});
                        occ++;
                    end
                end
                if (k == fs_k)  frame_start = 1'b1;
                if (k == clr_k) clear_req = 1'b1;
                step();
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        frame_start = 1'b0;
        clear_req = 1'b0;
        host_wr_valid = 1'b0;
        host_wr_addr = '0;
        host_wr_data = '0;
        host_rd_addr = '0;
        pre_en = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        #1;
        for (int j = 0; j < 32; j++) begin
            pre_en     = 1'b1;
            pre_addr   = 5'(j);
            pre_data   = 16'(j * 16'h0101);
            ref_mem[j] = 16'(j * 16'h0101);
            step();
        end
        pre_en = 1'b0;

        chk("rst_ready", 32'(host_wr_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_scan_valid", 32'(scan_valid), 32'd0);
        chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_rd_data", 32'(host_rd_data), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        step();
        chk("post_rst_ready", 32'(host_wr_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Single host write of 0xBEEF to layer 3 and its readback.
        host_wr_valid = 1'b1;
        host_wr_addr  = 5'd3;
        host_wr_data  = 16'hBEEF;
        step();
        host_wr_valid = 1'b0;
        chk("beef_wr_en", 32'(mem_wr_en), 32'd1);
        chk("beef_wr_addr", 32'(mem_wr_addr), 32'd3);
        chk("beef_wr_data", 32'(mem_wr_data), 32'hBEEF);
        host_rd_addr = 5'd3;
        ref_mem[3] = 16'hBEEF;
        step();
        chk("beef_single_wr", 32'(mem_wr_en), 32'd0);
        step();
        chk("beef_readback", 32'(host_rd_data), 32'hBEEF);

        wr_burst(8);
        step();
        rd_check(6);

        // Plain scan of the preloaded image.
        scan_run(1'b1, 0, -1, -1, 33);
        step();
        chk("post_scan_valid", 32'(scan_valid), 32'd0);
        chk("post_scan_done", 32'(scan_done), 32'd0);

        // Six writes during a scan: four buffered, drained in order once IDLE.
        scan_run(1'b1, 6, -1, -1, 33);
        while (exp_q.size() > 0) begin
            chk("drain_wr_en", 32'(mem_wr_en), 32'd1);
            chk("drain_wr_addr", 32'(mem_wr_addr), 32'(exp_q[0].a));
            chk("drain_wr_data", 32'(mem_wr_data), 32'(exp_q[0].d));
            ref_mem[exp_q[0].a] = exp_q[0].d;
            void'(exp_q.pop_front());
            step();
        end
        chk("drain_done", 32'(mem_wr_en), 32'd0);
        chk("drain_ready", 32'(host_wr_ready), 32'd1);
        rd_check(4);

        // Clear requested mid-scan, frame requested mid-clear.
        scan_run(1'b1, 0, -1, 15, 33);
        chk("pend_clr_idle_wr", 32'(mem_wr_en), 32'd0);
        step();
        for (int i = 0; i < 32; i++) begin
            frame_start = 1'b0;
            clear_req   = 1'b0;
            chk("clr_busy", 32'(busy), 32'd1);
            chk("clr_wr_en", 32'(mem_wr_en), 32'd1);
            chk("clr_wr_addr", 32'(mem_wr_addr), 32'(i));
            chk("clr_wr_data", 32'(mem_wr_data), 32'd0);
            ref_mem[i] = 16'h0000;
            if (i == 5)  frame_start = 1'b1;
            if (i == 10) clear_req = 1'b1;
            step();
        end
        frame_start = 1'b0;
        clear_req   = 1'b0;
        chk("clr_end_busy", 32'(busy), 32'd0);
        scan_run(1'b0, 0, -1, -1, 33);
        step();
        chk("no_second_clear_busy", 32'(busy), 32'd0);
        chk("no_second_clear_wr", 32'(mem_wr_en), 32'd0);

        // Repopulate, then a dropped frame_start at scan beat 10.
        wr_burst(8);
        step();
        scan_run(1'b1, 0, 12, -1, 33);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("drop_busy", 32'(busy), 32'd0);
            chk("drop_scan_valid", 32'(scan_valid), 32'd0);
            chk("drop_overrun", 32'(overrun), 32'd0);
        end

        // Reset at scan beat 5 with two writes parked in the FIFO.
        scan_run(1'b1, 2, -1, -1, 7);
        reset = 1'b1;
        #1;
        chk("abort_scan_valid", 32'(scan_valid), 32'd0);
        chk("abort_scan_data", 32'(scan_data), 32'd0);
        chk("abort_scan_layer", 32'(scan_layer), 32'd0);
        chk("abort_scan_done", 32'(scan_done), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(host_wr_ready), 32'd0);
        chk("abort_wr_en", 32'(mem_wr_en), 32'd0);
        chk("abort_rd_data", 32'(host_rd_data), 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("after_abort_busy", 32'(busy), 32'd0);
            chk("after_abort_wr_en", 32'(mem_wr_en), 32'd0);
            chk("after_abort_valid", 32'(scan_valid), 32'd0);
            chk("after_abort_done", 32'(scan_done), 32'd0);
            chk("after_abort_ready", 32'(host_wr_ready), 32'd1);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/layer_reg_scheduler.md
Name: layer_reg_scheduler

Overview:
- Sequences access to one per-register layer memory bank: 32 entries, 16-bit, two async read ports, one sync write port.
- Arbitrates between three requesters: host register writes (buffered in a small FIFO), a per-frame render scan that streams all layers' values in order, and a bulk clear.
- Host writes are deferred while a scan runs, so every frame sees a coherent register set.
- Sits between the host register interface / render pipeline and the layer register memory.

Parameters:
- NUM_LAYERS, 32: number of layer entries scanned and cleared (≤ 2^ADDR_W).
- ADDR_W, 5: layer address width.
- DATA_W, 16: register data width.
- FIFO_DEPTH, 4: host write buffer depth (power of 2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active high.
- frame_start  in  1  single-cycle request to scan all layers.
- clear_req  in  1  single-cycle request to zero all entries.
- host_wr_valid  in  1  host write request.
- host_wr_ready  out  1  FIFO can accept a write.
- host_wr_addr  in  ADDR_W  host write layer index.
- host_wr_data  in  DATA_W  host write data.
- host_rd_addr  in  ADDR_W  host readback layer index.
- host_rd_data  out  DATA_W  registered readback data.
- scan_valid  out  1  scan_data/scan_layer valid.
- scan_layer  out  ADDR_W  layer index of scan_data.
- scan_data  out  DATA_W  scanned register value.
- scan_done  out  1  pulse with the last scan beat.
- busy  out  1  state != IDLE.
- overrun  out  1  pulse: frame_start dropped.
- mem_rd_addr1  out  ADDR_W  memory read port 1 address (scan).
- mem_rd_addr2  out  ADDR_W  memory read port 2 address (host).
- mem_rd_data1  in  DATA_W  memory read port 1 data (async).
- mem_rd_data2  in  DATA_W  memory read port 2 data (async).
- mem_wr_en  out  1  memory write enable.
- mem_wr_addr  out  ADDR_W  memory write address.
- mem_wr_data  out  DATA_W  memory write data.

Behaviour:
- Reset (async, active high):
  - state IDLE; idx 0; FIFO empty; pending_frame/pending_clear 0.
  - All registered outputs 0; mem_wr_en 0; host_wr_ready 0 while reset is high.
  - Reset mid-scan or mid-clear aborts immediately; no scan_done.
- FSM states: IDLE, SCAN, CLEAR.
- IDLE:
  - If FIFO is non-empty: mem_wr_en=1, addr/data = FIFO head, pop; one write per cycle.
  - Next state by priority: (clear_req | pending_clear) → CLEAR; else (frame_start | pending_frame) → SCAN.
  - Taking a request clears its pending flag.
  - A FIFO write issued in the same cycle still completes.
- SCAN:
  - mem_rd_addr1 = idx; idx steps 0..NUM_LAYERS-1, one per cycle.
  - Next cycle: scan_valid=1, scan_layer=previous idx, scan_data=registered mem_rd_data1.
  - frame_start sampled in IDLE at cycle T → scan beats for layers 0..31 at T+2..T+33, back-to-back.
  - scan_done=1 at T+33 with layer 31; state is IDLE from T+33.
  - No FIFO pops during SCAN.
  - frame_start during SCAN → dropped; overrun pulses 1 cycle later.
  - clear_req during SCAN → pending_clear=1.
- CLEAR:
  - mem_wr_en=1, mem_wr_data=0, mem_wr_addr=idx; idx 0..NUM_LAYERS-1, one per cycle; then IDLE.
  - No FIFO pops during CLEAR.
  - frame_start during CLEAR → pending_frame=1.
  - clear_req during CLEAR → ignored.
- FIFO:
  - host_wr_ready = !full.
  - Push on valid & ready. No push when full, even if a pop occurs that cycle.
  - No bypass: a push into an empty FIFO writes memory no earlier than the next IDLE cycle.
  - Occupancy wraps via ADDR pointers plus an extra MSB.
  - Order preserved; last write to the same address wins.
- Host readback: mem_rd_addr2 = host_rd_addr; host_rd_data registers mem_rd_data2 every cycle, 1-cycle latency, in any state.
- idx wraps to 0 on exit from SCAN or CLEAR.

Test Plan:
- Reset release, then a host write (addr 3, 0xBEEF) in IDLE → mem_wr_en with addr 3 / 0xBEEF one cycle after accept; readback of addr 3 two cycles later gives 0xBEEF.
- Memory preloaded with data=layer*0x0101, frame_start at T → 32 consecutive scan beats T+2..T+33, layer 31 data 0x1F1F, scan_done only at T+33.
- 6 writes issued during SCAN → 4 accepted, host_wr_ready low at full; zero mem_wr_en until SCAN ends; then 4 writes in FIFO order on consecutive cycles.
- clear_req during SCAN plus frame_start during the following CLEAR → scan completes, then 32 zero-writes, then a second scan returning all zeros.
- frame_start at scan beat 10 → overrun single pulse; no second scan.
- reset asserted at scan beat 5 → all outputs 0 immediately; no scan_done; after release, busy=0 and FIFO empty.
